// File: rtl/aes_inv_ark_stage.sv
// aes_inv_ark_stage
// Registered AddRoundKey stage for the AES decryption datapath. Each accepted
// transfer is XORed with its round key and tagged with the key index it used,
// so the downstream inverse MixColumns block knows whether to apply or bypass.
// A 2-entry FIFO decouples upstream from downstream with valid/ready.
//
// Optional feature: define INV_ARK_ERR_EN to enable the sticky sequence error
// flag (restart mid-block, or a block that starts without in_first).
// Without it, err is tied low and the same sequences are handled silently.
module aes_inv_ark_stage #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_first,
    input  logic [127:0] in_state,
    input  logic [127:0] in_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         out_mix,
    output logic         out_last,
    output logic [3:0]   out_round,
    output logic         err
);

    localparam logic [3:0] LAST_KEY = 4'(NR);

    typedef struct packed {
        logic [127:0] state;
        logic [3:0]   round;
    } entry_t;

    entry_t      fifo_mem [2];
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  count;
    logic [3:0]  rnd;
    logic        busy;
    logic        push;
    logic        pop;
    logic [3:0]  in_tag;
    entry_t      head;

    // Handshake qualifiers and the tag for the transfer being offered. While
    // idle, rnd always sits at NR, so an idle transfer is tagged as a block start.
    always_comb begin
        push   = in_valid && in_ready;
        pop    = out_valid && out_ready;
        in_tag = (in_first || !busy) ? LAST_KEY : rnd;
        head   = fifo_mem[rd_ptr];
    end

    // in_ready depends only on the registered occupancy, never on out_ready.
    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign out_state = head.state;
    assign out_round = head.round;
    assign out_mix   = (head.round != LAST_KEY) && (head.round != 4'd0);
    assign out_last  = (head.round == 4'd0);

    // Two-entry FIFO: XOR and tag are captured at write so the head entry
    // drives the outputs directly and holds still under backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                fifo_mem[i] <= '{state: '0, round: LAST_KEY};
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= '{state: in_state ^ in_key, round: in_tag};
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Round tracking: a block runs from key index NR down to 0. Any accepted
    // transfer that is not the final one leaves the stage busy, so a transfer
    // arriving while idle acts as an implicit block start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rnd  <= LAST_KEY;
            busy <= 1'b0;
        end else if (push) begin
            if (in_tag == 4'd0) begin
                rnd  <= LAST_KEY;
                busy <= 1'b0;
            end else begin
                rnd  <= in_tag - 4'd1;
                busy <= 1'b1;
            end
        end
    end

`ifdef INV_ARK_ERR_EN
    logic err_q;

    // Sticky flag for a restart mid-block or a non-first transfer while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (push && (in_first == busy)) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_aes_inv_ark_stage.sv
// tb_aes_inv_ark_stage
// Directed self-checking bench for aes_inv_ark_stage with NR=10. Expected
// values are hand-computed constants or simple bench-side XOR/round models.
// Builds with or without INV_ARK_ERR_EN; the expected err level follows it.
module tb_aes_inv_ark_stage;

`ifdef INV_ARK_ERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic         in_first;
    logic [127:0] in_state;
    logic [127:0] in_key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
    logic         out_mix;
    logic         out_last;
    logic [3:0]   out_round;
    logic         err;

    int assertCount = 0;
    int failCount   = 0;

    aes_inv_ark_stage #(.NR(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_first  (in_first),
        .in_state  (in_state),
        .in_key    (in_key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state),
        .out_mix   (out_mix),
        .out_last  (out_last),
        .out_round (out_round),
        .err       (err)
    );

    // 100 MHz free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one transfer's inputs (held until changed).
    task automatic applyStimulus(input logic valid, input logic first,
                                 input logic [127:0] st, input logic [127:0] key);
        in_valid = valid;
        in_first = first;
        in_state = st;
        in_key   = key;
    endtask

    // Synchronous-looking pulse of the asynchronous reset, released off-edge.
    task automatic doReset();
        applyStimulus(1'b0, 1'b0, '0, '0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    logic [127:0] vecA, keyA, expA;
    logic [127:0] vecB, keyB, expB;
    logic [127:0] vecC, keyC, expC;
    logic [127:0] blkKey;
    logic [127:0] rndState, rndKey;

    initial begin
        vecA = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        keyA = 128'h13111d7fe3944a17f307a78b4d2b30c5;
        expA = 128'h7ad5fda789ef4e272bca100b3d9ff59f;
        vecB = 128'h00112233445566778899aabbccddeeff;
        keyB = 128'h000102030405060708090a0b0c0d0e0f;
        expB = 128'h00102030405060708090a0b0c0d0e0f0;
        vecC = {16{8'hff}};
        keyC = {16{8'h0f}};
        expC = {16{8'hf0}};
        blkKey = {16{8'h5a}};

        rst       = 1'b1;
        out_ready = 1'b0;
        applyStimulus(1'b0, 1'b0, '0, '0);
        #1;

        // Reset values.
        checkOutput("rst_in_ready",  128'(in_ready),  128'd1);
        checkOutput("rst_out_valid", 128'(out_valid), 128'd0);
        checkOutput("rst_out_state", out_state,       128'd0);
        checkOutput("rst_out_mix",   128'(out_mix),   128'd0);
        checkOutput("rst_out_last",  128'(out_last),  128'd0);
        checkOutput("rst_out_round", 128'(out_round), 128'd10);
        checkOutput("rst_err",       128'(err),       128'd0);
        tick();
        rst = 1'b0;

        // Single transfer with the reference vector.
        out_ready = 1'b1;
        applyStimulus(1'b1, 1'b1, vecA, keyA);
        tick();
        applyStimulus(1'b0, 1'b0, '0, '0);
        checkOutput("single_valid", 128'(out_valid), 128'd1);
        checkOutput("single_state", out_state,       expA);
        checkOutput("single_round", 128'(out_round), 128'd10);
        checkOutput("single_mix",   128'(out_mix),   128'd0);
        checkOutput("single_last",  128'(out_last),  128'd0);

        // Full block of 11 back-to-back transfers.
        doReset();
        out_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            checkOutput($sformatf("blk_in_ready_%0d", i), 128'(in_ready), 128'd1);
            applyStimulus(1'b1, (i == 0), {16{8'(i * 17)}}, blkKey);
            tick();
            checkOutput($sformatf("blk_valid_%0d", i), 128'(out_valid), 128'd1);
            checkOutput($sformatf("blk_state_%0d", i), out_state, {16{8'(i * 17)}} ^ blkKey);
            checkOutput($sformatf("blk_round_%0d", i), 128'(out_round), 128'(10 - i));
            checkOutput($sformatf("blk_mix_%0d", i), 128'(out_mix),
                        128'((i != 0) && (i != 10)));
            checkOutput($sformatf("blk_last_%0d", i), 128'(out_last), 128'(i == 10));
        end
        applyStimulus(1'b0, 1'b0, '0, '0);
        tick();
        checkOutput("blk_drained", 128'(out_valid), 128'd0);

        // Backpressure: fill the buffer, offer a third, then drain in order.
        doReset();
        out_ready = 1'b0;
        applyStimulus(1'b1, 1'b1, vecA, keyA);
        tick();
        checkOutput("bp_valid_1",    128'(out_valid), 128'd1);
        checkOutput("bp_in_ready_1", 128'(in_ready),  128'd1);
        checkOutput("bp_head_1",     out_state,       expA);
        applyStimulus(1'b1, 1'b0, vecB, keyB);
        tick();
        checkOutput("bp_in_ready_2", 128'(in_ready),  128'd0);
        checkOutput("bp_head_2",     out_state,       expA);
        applyStimulus(1'b1, 1'b0, vecC, keyC);
        tick();
        checkOutput("bp_in_ready_3", 128'(in_ready),  128'd0);
        checkOutput("bp_head_3",     out_state,       expA);
        checkOutput("bp_round_3",    128'(out_round), 128'd10);
        out_ready = 1'b1;
        tick();
        checkOutput("bp_pop1_state", out_state,       expB);
        checkOutput("bp_pop1_round", 128'(out_round), 128'd9);
        checkOutput("bp_pop1_ready", 128'(in_ready),  128'd1);
        tick();
        applyStimulus(1'b0, 1'b0, '0, '0);
        checkOutput("bp_pop2_state", out_state,       expC);
        checkOutput("bp_pop2_round", 128'(out_round), 128'd8);
        checkOutput("bp_pop2_mix",   128'(out_mix),   128'd1);
        tick();
        checkOutput("bp_drained",    128'(out_valid), 128'd0);

        // Simultaneous push and pop with one entry resident, random data.
        doReset();
        out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            rndState = {$urandom, $urandom, $urandom, $urandom};
            rndKey   = {$urandom, $urandom, $urandom, $urandom};
            applyStimulus(1'b1, ((k % 11) == 0), rndState, rndKey);
            tick();
            checkOutput($sformatf("pp_state_%0d", k), out_state, rndState ^ rndKey);
            checkOutput($sformatf("pp_round_%0d", k), 128'(out_round), 128'(10 - (k % 11)));
            checkOutput($sformatf("pp_ready_%0d", k), 128'(in_ready), 128'd1);
        end
        applyStimulus(1'b0, 1'b0, '0, '0);
        tick();
        checkOutput("pp_drained", 128'(out_valid), 128'd0);

        // Restart mid-block at key index 5.
        doReset();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, (i == 0), vecB, keyB);
            tick();
        end
        checkOutput("seq_err_before", 128'(err), 128'd0);
        applyStimulus(1'b1, 1'b1, vecA, keyA);
        tick();
        applyStimulus(1'b0, 1'b0, '0, '0);
        checkOutput("seq_restart_round", 128'(out_round), 128'd10);
        checkOutput("seq_err_set",       128'(err),       128'(ERR_EN));
        tick();
        checkOutput("seq_err_sticky",    128'(err),       128'(ERR_EN));
        doReset();
        checkOutput("seq_err_cleared",   128'(err),       128'd0);

        // Reset mid-block with two entries buffered.
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, (i == 0), vecC, keyC);
            tick();
        end
        out_ready = 1'b0;
        applyStimulus(1'b1, 1'b0, vecB, keyB);
        tick();
        applyStimulus(1'b0, 1'b0, '0, '0);
        checkOutput("mid_full",       128'(in_ready),  128'd0);
        checkOutput("mid_head_round", 128'(out_round), 128'd5);
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_valid", 128'(out_valid), 128'd0);
        checkOutput("mid_rst_ready", 128'(in_ready),  128'd1);
        #2;
        rst = 1'b0;
        out_ready = 1'b1;
        applyStimulus(1'b1, 1'b1, vecA, keyA);
        tick();
        applyStimulus(1'b0, 1'b0, '0, '0);
        checkOutput("mid_new_valid", 128'(out_valid), 128'd1);
        checkOutput("mid_new_round", 128'(out_round), 128'd10);
        checkOutput("mid_new_state", out_state,       expA);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/aes_inv_ark_stage.md
# aes_inv_ark_stage

Registered AddRoundKey stage for the AES decryption datapath. It sits directly upstream of the combinational inverse MixColumns block. It XORs each incoming 128-bit state with its round key and tags every result with the round position, so downstream logic knows whether to apply inverse MixColumns or bypass it on the initial and final key additions. It also decouples the upstream InvSubBytes/InvShiftRows path from downstream with a valid/ready handshake and a 2-entry skid buffer.

## Interface
- NR, 10, number of cipher rounds (10/12/14 for AES-128/192/256); each block is NR+1 transfers
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  upstream has a transfer
- in_ready  out  1  stage can accept; registered, not a function of out_ready
- in_first  in  1  transfer is the first (w[NR]) key addition of a block
- in_state  in  128  state bytes, [127:120] = byte 0
- in_key  in  128  round key for this transfer
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts
- out_state  out  128  in_state ^ in_key
- out_mix  out  1  1 = downstream must apply inverse MixColumns
- out_last  out  1  1 = final (w[0]) addition; out_state is plaintext
- out_round  out  4  key index used, NR down to 0
- err  out  1  sticky sequence error

## Operation
- Transfer in: in_valid & in_ready at the clk edge. Transfer out: out_valid & out_ready.
- The round counter rnd (4 bits) holds the key index of the next expected transfer. Reset value is NR. The idle flag busy resets to 0.
- On an accepted input:
  - If in_first=1, the entry is tagged round NR, busy is set, and rnd is set to NR-1.
  - Otherwise the entry is tagged with the current rnd, and rnd decrements.
  - The entry tagged 0 clears busy and reloads rnd to NR.
- Tag decode:
  - out_mix = (round != NR) && (round != 0).
  - out_last = (round == 0).
- Storage is a 2-entry FIFO of {state^key, round}. The XOR is computed at entry write.
  - in_ready = (count < 2).
  - out_* are driven from the head entry. out_valid = (count != 0).
- Simultaneous push and pop: the count is unchanged and ordering is preserved. A push while count==2 is impossible because in_ready=0.
- Outputs remain stable while out_valid=1 and out_ready=0.
- Reset mid-block: the FIFO empties and rnd=NR, busy=0, err=0. Any partial block is discarded.

## Timing
- Latency: 1 cycle from an accepted input to out_valid.
- Throughput: 1 transfer per cycle while out_ready=1.
- in_ready recovers the cycle after any pop from a full buffer.
- Reset values: in_ready=1, out_valid=0, out_state=0, out_mix=0, out_last=0, out_round=NR, err=0.

## Configuration
- Macro `INV_ARK_ERR_EN`, when defined:
  - err is set (sticky until rst) on either of two conditions:
    - in_first=1 is accepted while busy=1, i.e. a restart mid-block.
    - in_first=0 is accepted while busy=0, i.e. a missing start.
  - For a restart mid-block, the transfer is still processed as a new block start.
  - For a missing start, the transfer is processed with the tag from the current rnd=NR.
- When not defined:
  - err is tied to 0.
  - Both cases are processed identically to the defined case, but silently.

## Test plan
- Single transfer, NR=10, in_first=1, in_state=69c4e0d86a7b0430d8cdb78070b4c55a, in_key=13111d7fe3944a17f307a78b4d2b30c5, out_ready=1 -> next cycle out_valid=1, out_state=7ad5fda789ef4e272bca100b3d9ff59f, out_round=10, out_mix=0, out_last=0.
- Full block of 11 back-to-back transfers with out_ready=1:
  - out_round sequence is 10,9,…,0.
  - out_mix=1 exactly for rounds 9..1.
  - out_last=1 only on round 0.
  - in_ready stays 1 throughout.
- Backpressure: hold out_ready=0 and push 3 transfers.
  - The first 2 are accepted and in_ready=0 after the second.
  - The head output stays stable.
  - Release out_ready -> entries drain in order, and the third transfer is accepted the cycle after the first pop.
- Simultaneous push and pop with count==1 over 20 cycles of random data -> no loss or reordering; count stays 1.
- With `INV_ARK_ERR_EN`: assert in_first at round 5 of a block.
  - err=1 the next cycle and remains 1.
  - That transfer is tagged 10.
  - rst clears err; without the macro, err stays 0.
- Assert rst at round 4 with 2 entries buffered -> out_valid=0, in_ready=1 immediately. The next in_first transfer is tagged 10.
